// File: rtl/platform_ctrl_pkg.sv
// platform_ctrl_pkg: screen geometry, platform field constants and FSM encodings
// shared by platform_ctrl and the doodle state machine.
package platform_ctrl_pkg;
    localparam int NPLAT    = 8;
    localparam int PLAT_W   = 40;
    localparam int DOODLE_W = 20;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int MID_Y    = 240;
    localparam int LAND_TOL = 4;
    localparam int SPAWN_X0 = 32;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    typedef enum logic [2:0] {IDLE, INIT, SCAN, UPD, REPORT} state_t;
    function automatic logic [9:0] spawn_x(input logic [8:0] rnd);
        return 10'(SPAWN_X0) + {1'b0, rnd};
    endfunction
endpackage

// File: rtl/platform_ctrl_lfsr.sv
// platform_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on reset;
// exposes only the low bits the platform spawner consumes.
module platform_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 9
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    output logic [OUT_W-1:0] value
);
    logic [15:0] state;
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset)
            state <= SEED;
        else if (en)
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    assign value = state[OUT_W-1:0];
endmodule

// File: rtl/platform_ctrl.sv
// platform_ctrl: owns the platform field, checks doodle landings and scrolls/respawns
// platforms one entry per cycle over a Tick-driven step.
module platform_ctrl
    import platform_ctrl_pkg::*;
#(
    parameter int NPLAT_P    = NPLAT,
    parameter int PLAT_W_P   = PLAT_W,
    parameter int DOODLE_W_P = DOODLE_W,
    parameter int SCREEN_H_P = SCREEN_H,
    parameter int MID_Y_P    = MID_Y,
    parameter int LAND_TOL_P = LAND_TOL
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Init,
    input  logic                       Tick,
    input  logic                       Rising,
    input  logic                       Falling,
    input  logic [9:0]                 Doodle_x,
    input  logic [9:0]                 Doodle_y,
    input  logic [$clog2(NPLAT_P)-1:0] Rd_idx,
    output logic [9:0]                 Rd_x,
    output logic [9:0]                 Rd_y,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Hit,
    output logic                       Bottom,
    output logic                       Scroll
);
    localparam int IW = $clog2(NPLAT_P);
    state_t          state;
    logic [IW-1:0]   cnt;
    logic [9:0]      px [NPLAT_P];
    logic [9:0]      py [NPLAT_P];
    logic            rising_l, falling_l, hit_acc;
    logic [9:0]      dx_l, dy_l;
    logic [8:0]      rnd;
    logic [9:0]      cur_x, cur_y;
    logic [10:0]     ny;
    logic            land, scroll_c, last;

    platform_lfsr #(.SEED(LFSR_SEED), .OUT_W(9)) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (1'b1),
        .value (rnd)
    );

    // 11-bit compares keep x+PLAT_W and y+LAND_TOL from wrapping
    always_comb begin
        cur_x    = px[cnt];
        cur_y    = py[cnt];
        ny       = {1'b0, cur_y} + 11'd1;
        last     = cnt == IW'(NPLAT_P - 1);
        scroll_c = rising_l && dy_l < 10'(MID_Y_P);
        land     = falling_l
                && ({1'b0, dx_l} + 11'(DOODLE_W_P) > {1'b0, cur_x})
                && ({1'b0, dx_l} < {1'b0, cur_x} + 11'(PLAT_W_P))
                && ({1'b0, dy_l} >= {1'b0, cur_y})
                && ({1'b0, dy_l} < {1'b0, cur_y} + 11'(LAND_TOL_P));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            for (int i = 0; i < NPLAT_P; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
            Rd_x      <= '0;
            Rd_y      <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Hit       <= 1'b0;
            Bottom    <= 1'b0;
            Scroll    <= 1'b0;
            rising_l  <= 1'b0;
            falling_l <= 1'b0;
            dx_l      <= '0;
            dy_l      <= '0;
            hit_acc   <= 1'b0;
        end else begin
            Rd_x   <= px[Rd_idx];
            Rd_y   <= py[Rd_idx];
            Done   <= 1'b0;
            Hit    <= 1'b0;
            Bottom <= 1'b0;
            Scroll <= 1'b0;
            // Init wins everywhere: it also aborts a step in flight without a Done
            if (Init) begin
                state <= INIT;
                cnt   <= '0;
                Busy  <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: if (Tick) begin
                        rising_l  <= Rising;
                        falling_l <= Falling;
                        dx_l      <= Doodle_x;
                        dy_l      <= Doodle_y;
                        hit_acc   <= 1'b0;
                        cnt       <= '0;
                        Busy      <= 1'b1;
                        state     <= SCAN;
                    end
                    INIT: begin
                        px[cnt] <= spawn_x(rnd);
                        py[cnt] <= 10'd20 + 10'd60 * 10'(cnt);
                        cnt     <= last ? '0 : cnt + 1'b1;
                        Busy    <= !last;
                        state   <= last ? IDLE : INIT;
                    end
                    SCAN: begin
                        hit_acc <= hit_acc | land;
                        cnt     <= last ? '0 : cnt + 1'b1;
                        state   <= last ? UPD : SCAN;
                    end
                    UPD: begin
                        if (scroll_c) begin
                            py[cnt] <= ny >= 11'(SCREEN_H_P) ? '0 : ny[9:0];
                            px[cnt] <= ny >= 11'(SCREEN_H_P) ? spawn_x(rnd) : cur_x;
                        end
                        cnt   <= last ? '0 : cnt + 1'b1;
                        state <= last ? REPORT : UPD;
                    end
                    REPORT: begin
                        Done   <= 1'b1;
                        Hit    <= hit_acc;
                        Bottom <= falling_l && dy_l >= 10'(SCREEN_H_P - 1) && !hit_acc;
                        Scroll <= scroll_c;
                        Busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
